// File: rtl/rvh_tlb_miss_arbiter.sv
// N-channel TLB miss arbiter onto the shared next-level miss port, with outstanding limits and flush drain.
// Define RVH_TLB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.

module rvh_tlb_miss_arbiter_chk #(
    parameter int NUM_CH = 2
) (
    input logic              clk,
    input logic              rstn,
    input logic              nl_resp_vld_i,
    input logic              resp_legal_i,
    input logic [NUM_CH-1:0] grant_oh_i
);
    // Flag responses that are dropped and check the grant vector is at most one-hot
    always @(posedge clk) begin
        if (rstn) begin
            if (nl_resp_vld_i) begin
                assert (resp_legal_i) else $warning("rvh_tlb_miss_arbiter: illegal next-level response dropped");
            end
            assert ($onehot0(grant_oh_i)) else $error("rvh_tlb_miss_arbiter: multiple grants");
        end
    end
endmodule

module rvh_tlb_miss_arbiter #(
    parameter  int NUM_CH          = 2,
    parameter  int TRANS_ID_WIDTH  = 2,
    parameter  int ASID_WIDTH      = 16,
    parameter  int VPN_WIDTH       = 27,
    parameter  int PTE_WIDTH       = 64,
    parameter  int PAGE_LVL_WIDTH  = 2,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int CH_ID_WIDTH     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int NL_ID_WIDTH     = CH_ID_WIDTH + TRANS_ID_WIDTH
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_CH-1:0]                ch_req_vld_i,
    input  logic [NUM_CH*TRANS_ID_WIDTH-1:0] ch_req_trans_id_i,
    input  logic [NUM_CH*ASID_WIDTH-1:0]     ch_req_asid_i,
    input  logic [NUM_CH*VPN_WIDTH-1:0]      ch_req_vpn_i,
    input  logic [NUM_CH*2-1:0]              ch_req_access_type_i,
    output logic [NUM_CH-1:0]                ch_req_rdy_o,
    output logic [NUM_CH-1:0]                ch_resp_vld_o,
    output logic [TRANS_ID_WIDTH-1:0]        ch_resp_trans_id_o,
    output logic [ASID_WIDTH-1:0]            ch_resp_asid_o,
    output logic [VPN_WIDTH-1:0]             ch_resp_vpn_o,
    output logic [PTE_WIDTH-1:0]             ch_resp_pte_o,
    output logic [PAGE_LVL_WIDTH-1:0]        ch_resp_page_lvl_o,
    output logic [1:0]                       ch_resp_access_type_o,
    output logic                             ch_resp_access_fault_o,
    output logic                             ch_resp_page_fault_o,
    output logic                             nl_req_vld_o,
    output logic [NL_ID_WIDTH-1:0]           nl_req_trans_id_o,
    output logic [ASID_WIDTH-1:0]            nl_req_asid_o,
    output logic [VPN_WIDTH-1:0]             nl_req_vpn_o,
    output logic [1:0]                       nl_req_access_type_o,
    input  logic                             nl_req_rdy_i,
    input  logic                             nl_resp_vld_i,
    input  logic [NL_ID_WIDTH-1:0]           nl_resp_trans_id_i,
    input  logic [ASID_WIDTH-1:0]            nl_resp_asid_i,
    input  logic [VPN_WIDTH-1:0]             nl_resp_vpn_i,
    input  logic [PTE_WIDTH-1:0]             nl_resp_pte_i,
    input  logic [PAGE_LVL_WIDTH-1:0]        nl_resp_page_lvl_i,
    input  logic [1:0]                       nl_resp_access_type_i,
    input  logic                             nl_resp_access_fault_i,
    input  logic                             nl_resp_page_fault_i,
    input  logic                             flush_vld_i,
    output logic                             flush_grant_o
);
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    logic                      req_vld_q, req_vld_d;
    logic [NL_ID_WIDTH-1:0]    req_id_q, req_id_d;
    logic [ASID_WIDTH-1:0]     req_asid_q, req_asid_d;
    logic [VPN_WIDTH-1:0]      req_vpn_q, req_vpn_d;
    logic [1:0]                req_at_q, req_at_d;
    logic [2:0]                cnt_q [NUM_CH];
    logic [2:0]                cnt_d [NUM_CH];
    logic [CH_ID_WIDTH-1:0]    start_s;
    logic                      slot_free_s;
    logic [NUM_CH-1:0]         eligible_s;
    logic                      grant_found_s;
    logic                      grant_vld_s;
    logic [CH_ID_WIDTH-1:0]    grant_idx_s;
    logic [NUM_CH-1:0]         grant_oh_s;
    logic [CH_ID_WIDTH-1:0]    resp_ch_s;
    logic [NUM_CH-1:0]         resp_vld_s;
    logic                      all_idle_s;

    // First eligible channel at or after start, wrapping modulo NUM_CH; MSB of result flags a hit
    function automatic logic [CH_ID_WIDTH:0] pick_f(input logic [NUM_CH-1:0] elig,
                                                    input logic [CH_ID_WIDTH-1:0] start);
        logic                   found;
        logic [CH_ID_WIDTH-1:0] idx;
        int                     c;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (int'(start) + k) % NUM_CH;
            if (!found && elig[c]) begin
                found = 1'b1;
                idx   = CH_ID_WIDTH'(c);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

`ifdef RVH_TLB_ARB_FIXED_PRIO_EN
    assign start_s = '0;
`else
    logic [CH_ID_WIDTH-1:0] ptr_q, ptr_d;
    assign start_s = ptr_q;

    // Pointer moves just past the granted channel
    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld_s) begin
            ptr_d = (grant_idx_s == CH_ID_WIDTH'(NUM_CH - 1)) ? '0 : grant_idx_s + CH_ID_WIDTH'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign slot_free_s = ~req_vld_q | nl_req_rdy_i;
    assign resp_ch_s   = nl_resp_trans_id_i[NL_ID_WIDTH-1 -: CH_ID_WIDTH];

    // Eligibility, grant selection, response routing and idle detection
    always_comb begin
        all_idle_s = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible_s[i] = ch_req_vld_i[i] & (cnt_q[i] < MAX_CNT) & ~flush_vld_i;
            resp_vld_s[i] = nl_resp_vld_i & (resp_ch_s == CH_ID_WIDTH'(i)) & (cnt_q[i] != 3'd0);
            all_idle_s    = all_idle_s & (cnt_q[i] == 3'd0);
        end
        {grant_found_s, grant_idx_s} = pick_f(eligible_s, start_s);
        grant_vld_s = slot_free_s & grant_found_s;
        for (int i = 0; i < NUM_CH; i++) begin
            grant_oh_s[i] = grant_vld_s & (grant_idx_s == CH_ID_WIDTH'(i));
        end
    end

    // Request register: load on grant, otherwise empty when the next level takes it
    always_comb begin
        req_vld_d  = req_vld_q;
        req_id_d   = req_id_q;
        req_asid_d = req_asid_q;
        req_vpn_d  = req_vpn_q;
        req_at_d   = req_at_q;
        if (grant_vld_s) begin
            req_vld_d  = 1'b1;
            req_id_d   = {grant_idx_s, ch_req_trans_id_i[int'(grant_idx_s)*TRANS_ID_WIDTH +: TRANS_ID_WIDTH]};
            req_asid_d = ch_req_asid_i[int'(grant_idx_s)*ASID_WIDTH +: ASID_WIDTH];
            req_vpn_d  = ch_req_vpn_i[int'(grant_idx_s)*VPN_WIDTH +: VPN_WIDTH];
            req_at_d   = ch_req_access_type_i[int'(grant_idx_s)*2 +: 2];
        end else if (nl_req_rdy_i) begin
            req_vld_d  = 1'b0;
        end else begin
            req_vld_d  = req_vld_q;
        end
    end

    // Outstanding counters: acceptance adds, a legal response subtracts, both together cancel
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            case ({grant_oh_s[i], resp_vld_s[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 3'd1;
                2'b01:   cnt_d[i] = cnt_q[i] - 3'd1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Request register and counter state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_vld_q  <= 1'b0;
            req_id_q   <= '0;
            req_asid_q <= '0;
            req_vpn_q  <= '0;
            req_at_q   <= 2'b00;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= 3'd0;
            end
        end else begin
            req_vld_q  <= req_vld_d;
            req_id_q   <= req_id_d;
            req_asid_q <= req_asid_d;
            req_vpn_q  <= req_vpn_d;
            req_at_q   <= req_at_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign ch_req_rdy_o           = grant_oh_s;
    assign nl_req_vld_o           = req_vld_q;
    assign nl_req_trans_id_o      = req_id_q;
    assign nl_req_asid_o          = req_asid_q;
    assign nl_req_vpn_o           = req_vpn_q;
    assign nl_req_access_type_o   = req_at_q;
    assign ch_resp_vld_o          = resp_vld_s;
    assign ch_resp_trans_id_o     = nl_resp_trans_id_i[TRANS_ID_WIDTH-1:0];
    assign ch_resp_asid_o         = nl_resp_asid_i;
    assign ch_resp_vpn_o          = nl_resp_vpn_i;
    assign ch_resp_pte_o          = nl_resp_pte_i;
    assign ch_resp_page_lvl_o     = nl_resp_page_lvl_i;
    assign ch_resp_access_type_o  = nl_resp_access_type_i;
    assign ch_resp_access_fault_o = nl_resp_access_fault_i;
    assign ch_resp_page_fault_o   = nl_resp_page_fault_i;
    assign flush_grant_o          = flush_vld_i & ~req_vld_q & all_idle_s;

    rvh_tlb_miss_arbiter_chk #(.NUM_CH(NUM_CH)) u_chk (
        .clk           (clk),
        .rstn          (rstn),
        .nl_resp_vld_i (nl_resp_vld_i),
        .resp_legal_i  (|resp_vld_s),
        .grant_oh_i    (grant_oh_s)
    );
endmodule

// File: tb/tb_rvh_tlb_miss_arbiter.sv
// Self-checking bench for rvh_tlb_miss_arbiter: directed vector table, reset sequences, random run vs model.
module tb_rvh_tlb_miss_arbiter;
    localparam int NUM_CH = 2;
    localparam int TID    = 2;
    localparam int AW     = 16;
    localparam int VW     = 27;
    localparam int PW     = 64;
    localparam int LW     = 2;
    localparam int MAXO   = 2;
    localparam int NLW    = 3;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NUM_CH-1:0]     ch_req_vld_i;
    logic [NUM_CH*TID-1:0] ch_req_trans_id_i;
    logic [NUM_CH*AW-1:0]  ch_req_asid_i;
    logic [NUM_CH*VW-1:0]  ch_req_vpn_i;
    logic [NUM_CH*2-1:0]   ch_req_access_type_i;
    logic [NUM_CH-1:0]     ch_req_rdy_o;
    logic [NUM_CH-1:0]     ch_resp_vld_o;
    logic [TID-1:0]        ch_resp_trans_id_o;
    logic [AW-1:0]         ch_resp_asid_o;
    logic [VW-1:0]         ch_resp_vpn_o;
    logic [PW-1:0]         ch_resp_pte_o;
    logic [LW-1:0]         ch_resp_page_lvl_o;
    logic [1:0]            ch_resp_access_type_o;
    logic                  ch_resp_access_fault_o;
    logic                  ch_resp_page_fault_o;
    logic                  nl_req_vld_o;
    logic [NLW-1:0]        nl_req_trans_id_o;
    logic [AW-1:0]         nl_req_asid_o;
    logic [VW-1:0]         nl_req_vpn_o;
    logic [1:0]            nl_req_access_type_o;
    logic                  nl_req_rdy_i;
    logic                  nl_resp_vld_i;
    logic [NLW-1:0]        nl_resp_trans_id_i;
    logic [AW-1:0]         nl_resp_asid_i;
    logic [VW-1:0]         nl_resp_vpn_i;
    logic [PW-1:0]         nl_resp_pte_i;
    logic [LW-1:0]         nl_resp_page_lvl_i;
    logic [1:0]            nl_resp_access_type_i;
    logic                  nl_resp_access_fault_i;
    logic                  nl_resp_page_fault_i;
    logic                  flush_vld_i;
    logic                  flush_grant_o;

    rvh_tlb_miss_arbiter #(
        .NUM_CH(NUM_CH), .TRANS_ID_WIDTH(TID), .ASID_WIDTH(AW), .VPN_WIDTH(VW),
        .PTE_WIDTH(PW), .PAGE_LVL_WIDTH(LW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .ch_req_vld_i(ch_req_vld_i), .ch_req_trans_id_i(ch_req_trans_id_i),
        .ch_req_asid_i(ch_req_asid_i), .ch_req_vpn_i(ch_req_vpn_i),
        .ch_req_access_type_i(ch_req_access_type_i), .ch_req_rdy_o(ch_req_rdy_o),
        .ch_resp_vld_o(ch_resp_vld_o), .ch_resp_trans_id_o(ch_resp_trans_id_o),
        .ch_resp_asid_o(ch_resp_asid_o), .ch_resp_vpn_o(ch_resp_vpn_o),
        .ch_resp_pte_o(ch_resp_pte_o), .ch_resp_page_lvl_o(ch_resp_page_lvl_o),
        .ch_resp_access_type_o(ch_resp_access_type_o),
        .ch_resp_access_fault_o(ch_resp_access_fault_o), .ch_resp_page_fault_o(ch_resp_page_fault_o),
        .nl_req_vld_o(nl_req_vld_o), .nl_req_trans_id_o(nl_req_trans_id_o),
        .nl_req_asid_o(nl_req_asid_o), .nl_req_vpn_o(nl_req_vpn_o),
        .nl_req_access_type_o(nl_req_access_type_o), .nl_req_rdy_i(nl_req_rdy_i),
        .nl_resp_vld_i(nl_resp_vld_i), .nl_resp_trans_id_i(nl_resp_trans_id_i),
        .nl_resp_asid_i(nl_resp_asid_i), .nl_resp_vpn_i(nl_resp_vpn_i),
        .nl_resp_pte_i(nl_resp_pte_i), .nl_resp_page_lvl_i(nl_resp_page_lvl_i),
        .nl_resp_access_type_i(nl_resp_access_type_i),
        .nl_resp_access_fault_i(nl_resp_access_fault_i), .nl_resp_page_fault_i(nl_resp_page_fault_i),
        .flush_vld_i(flush_vld_i), .flush_grant_o(flush_grant_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] vld;
        logic       nrdy;
        logic       rsp_v;
        logic [2:0] rsp_tag;
        logic       flush;
        logic [1:0] e_rdy;
        logic       e_nl_vld;
        logic [2:0] e_nl_id;
        logic [1:0] e_rsp;
        logic       e_fg;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] vld, input logic nrdy, input logic rsp_v,
                                input logic [2:0] tag, input logic flush, input logic [1:0] e_rdy,
                                input logic e_nl_vld, input logic [2:0] e_nl_id,
                                input logic [1:0] e_rsp, input logic e_fg);
        vec_t v;
        v.vld = vld; v.nrdy = nrdy; v.rsp_v = rsp_v; v.rsp_tag = tag; v.flush = flush;
        v.e_rdy = e_rdy; v.e_nl_vld = e_nl_vld; v.e_nl_id = e_nl_id; v.e_rsp = e_rsp; v.e_fg = e_fg;
        return v;
    endfunction

    vec_t tbl[26];

    // Reference model state: in-flight per channel, request slot, pointer, delivered tags
    int         m_cnt[NUM_CH];
    int         m_ptr;
    logic       m_vld;
    logic [2:0] m_id;
    logic [AW-1:0] m_asid;
    logic [VW-1:0] m_vpn;
    logic [1:0] m_at;
    logic [2:0] delivered[$];
    int         g, c, rc, k, start;
    logic       slot_free, all0;
    logic [1:0] e_rdy, e_rsp;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        ch_req_vld_i = '0; ch_req_trans_id_i = '0; ch_req_asid_i = '0; ch_req_vpn_i = '0;
        ch_req_access_type_i = '0; nl_req_rdy_i = 1'b0; nl_resp_vld_i = 1'b0;
        nl_resp_trans_id_i = '0; nl_resp_asid_i = '0; nl_resp_vpn_i = '0; nl_resp_pte_i = '0;
        nl_resp_page_lvl_i = '0; nl_resp_access_type_i = '0; nl_resp_access_fault_i = 1'b0;
        nl_resp_page_fault_i = 1'b0; flush_vld_i = 1'b0;

        //            vld    nrdy  rv    tag     fl  | rdy  nlv   nlid    rsp   fg
        tbl[0]  = mk(2'b11, 1'b1, 1'b0, 3'b000, 1'b0, 2'b01, 1'b0, 3'b000, 2'b00, 1'b0);
        tbl[1]  = mk(2'b11, 1'b1, 1'b0, 3'b000, 1'b0, 2'b10, 1'b1, 3'b001, 2'b00, 1'b0);
        tbl[2]  = mk(2'b11, 1'b1, 1'b0, 3'b000, 1'b0, 2'b01, 1'b1, 3'b110, 2'b00, 1'b0);
        tbl[3]  = mk(2'b01, 1'b1, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 3'b001, 2'b00, 1'b0);
        tbl[4]  = mk(2'b01, 1'b1, 1'b1, 3'b001, 1'b0, 2'b00, 1'b0, 3'b000, 2'b01, 1'b0);
        tbl[5]  = mk(2'b01, 1'b1, 1'b0, 3'b000, 1'b0, 2'b01, 1'b0, 3'b000, 2'b00, 1'b0);
        tbl[6]  = mk(2'b00, 1'b1, 1'b1, 3'b110, 1'b0, 2'b00, 1'b1, 3'b001, 2'b10, 1'b0);
        tbl[7]  = mk(2'b00, 1'b1, 1'b1, 3'b100, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0);
        tbl[8]  = mk(2'b00, 1'b1, 1'b1, 3'b001, 1'b1, 2'b00, 1'b0, 3'b000, 2'b01, 1'b0);
        tbl[9]  = mk(2'b11, 1'b1, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 3'b000, 2'b00, 1'b0);
        tbl[10] = mk(2'b11, 1'b1, 1'b1, 3'b001, 1'b1, 2'b00, 1'b0, 3'b000, 2'b01, 1'b0);
        tbl[11] = mk(2'b11, 1'b1, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 3'b000, 2'b00, 1'b1);
        tbl[12] = mk(2'b01, 1'b1, 1'b0, 3'b000, 1'b0, 2'b01, 1'b0, 3'b000, 2'b00, 1'b0);
        tbl[13] = mk(2'b01, 1'b1, 1'b1, 3'b001, 1'b0, 2'b01, 1'b1, 3'b001, 2'b01, 1'b0);
        tbl[14] = mk(2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 3'b001, 2'b00, 1'b0);
        tbl[15] = mk(2'b00, 1'b1, 1'b0, 3'b000, 1'b1, 2'b00, 1'b1, 3'b001, 2'b00, 1'b0);
        tbl[16] = mk(2'b00, 1'b1, 1'b1, 3'b001, 1'b1, 2'b00, 1'b0, 3'b000, 2'b01, 1'b0);
        tbl[17] = mk(2'b00, 1'b1, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 3'b000, 2'b00, 1'b1);
        tbl[18] = mk(2'b11, 1'b0, 1'b0, 3'b000, 1'b0, 2'b10, 1'b0, 3'b000, 2'b00, 1'b0);
        for (int i = 19; i < 24; i++)
            tbl[i] = mk(2'b11, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 3'b110, 2'b00, 1'b0);
        tbl[24] = mk(2'b11, 1'b1, 1'b0, 3'b000, 1'b0, 2'b01, 1'b1, 3'b110, 2'b00, 1'b0);
        tbl[25] = mk(2'b00, 1'b1, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 3'b001, 2'b00, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_nl_vld", 64'(nl_req_vld_o), 64'd0);
        chk("reset_nl_id", 64'(nl_req_trans_id_o), 64'd0);
        chk("reset_rdy", 64'(ch_req_rdy_o), 64'd0);
        chk("reset_rsp_vld", 64'(ch_resp_vld_o), 64'd0);
        chk("reset_fg", 64'(flush_grant_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed vectors: fixed per-channel payloads, ids ch0=01 ch1=10
        ch_req_trans_id_i    = {2'b10, 2'b01};
        ch_req_asid_i        = {16'hA001, 16'hA000};
        ch_req_vpn_i         = {27'h1234561, 27'h1234560};
        ch_req_access_type_i = {2'd2, 2'd1};
        nl_resp_pte_i        = 64'hDEAD_BEEF_0123_4567;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            ch_req_vld_i = tbl[i].vld; nl_req_rdy_i = tbl[i].nrdy; nl_resp_vld_i = tbl[i].rsp_v;
            nl_resp_trans_id_i = tbl[i].rsp_tag; flush_vld_i = tbl[i].flush;
            #1;
            chk($sformatf("v%0d_rdy", i), 64'(ch_req_rdy_o), 64'(tbl[i].e_rdy));
            chk($sformatf("v%0d_nl_vld", i), 64'(nl_req_vld_o), 64'(tbl[i].e_nl_vld));
            if (tbl[i].e_nl_vld) begin
                chk($sformatf("v%0d_nl_id", i), 64'(nl_req_trans_id_o), 64'(tbl[i].e_nl_id));
                chk($sformatf("v%0d_nl_asid", i), 64'(nl_req_asid_o), 64'(16'hA000 + 16'(tbl[i].e_nl_id[2])));
                chk($sformatf("v%0d_nl_vpn", i), 64'(nl_req_vpn_o), 64'(27'h1234560 + 27'(tbl[i].e_nl_id[2])));
                chk($sformatf("v%0d_nl_at", i), 64'(nl_req_access_type_o), 64'(2'd1 + 2'(tbl[i].e_nl_id[2])));
            end
            chk($sformatf("v%0d_rsp_vld", i), 64'(ch_resp_vld_o), 64'(tbl[i].e_rsp));
            if (tbl[i].e_rsp != 2'b00) begin
                chk($sformatf("v%0d_rsp_id", i), 64'(ch_resp_trans_id_o), 64'(tbl[i].rsp_tag[1:0]));
                chk($sformatf("v%0d_rsp_pte", i), ch_resp_pte_o, 64'hDEAD_BEEF_0123_4567);
            end
            chk($sformatf("v%0d_fg", i), 64'(flush_grant_o), 64'(tbl[i].e_fg));
        end

        // Mid-operation reset with a request held in the register
        @(negedge clk);
        ch_req_vld_i = 2'b01; nl_req_rdy_i = 1'b0; nl_resp_vld_i = 1'b0; flush_vld_i = 1'b0;
        @(negedge clk);
        ch_req_vld_i = 2'b00;
        #1;
        chk("pre_reset_nl_vld", 64'(nl_req_vld_o), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_reset_nl_vld", 64'(nl_req_vld_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        flush_vld_i = 1'b1;
        #1;
        chk("post_reset_fg", 64'(flush_grant_o), 64'd1);
        @(negedge clk);
        flush_vld_i = 1'b0; nl_resp_vld_i = 1'b1; nl_resp_trans_id_i = 3'b001;
        #1;
        chk("post_reset_rsp_dropped", 64'(ch_resp_vld_o), 64'd0);
        @(negedge clk);
        nl_resp_vld_i = 1'b0;
        #1;
        chk("post_reset_cnt_clear_rdy", 64'(ch_req_rdy_o), 64'd0);

        // Randomized run against the transaction-level model
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
        m_ptr = 0; m_vld = 1'b0; m_id = '0; m_asid = '0; m_vpn = '0; m_at = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            ch_req_vld_i         = 2'($urandom_range(0, 3));
            ch_req_trans_id_i    = 4'($urandom);
            ch_req_asid_i        = {16'($urandom), 16'($urandom)};
            ch_req_vpn_i         = {27'($urandom), 27'($urandom)};
            ch_req_access_type_i = 4'($urandom);
            nl_req_rdy_i         = ($urandom_range(0, 3) != 0);
            flush_vld_i          = ($urandom_range(0, 11) == 0);
            nl_resp_pte_i        = {32'($urandom), 32'($urandom)};
            nl_resp_asid_i       = 16'($urandom);
            if (delivered.size() > 0 && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, delivered.size() - 1);
                nl_resp_trans_id_i = delivered[k];
                delivered.delete(k);
                nl_resp_vld_i = 1'b1;
            end else begin
                nl_resp_trans_id_i = 3'($urandom);
                nl_resp_vld_i = 1'b0;
            end
            #1;
`ifdef RVH_TLB_ARB_FIXED_PRIO_EN
            start = 0;
`else
            start = m_ptr;
`endif
            slot_free = !m_vld || nl_req_rdy_i;
            g = -1;
            if (slot_free && !flush_vld_i) begin
                for (int j = 0; j < NUM_CH; j++) begin
                    c = (start + j) % NUM_CH;
                    if (g < 0 && ch_req_vld_i[c] && m_cnt[c] < MAXO) g = c;
                end
            end
            e_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
            rc = int'(nl_resp_trans_id_i[2]);
            e_rsp = (nl_resp_vld_i && m_cnt[rc] > 0) ? 2'(1 << rc) : 2'b00;
            all0 = 1'b1;
            for (int j = 0; j < NUM_CH; j++) if (m_cnt[j] != 0) all0 = 1'b0;

            chk("rnd_rdy", 64'(ch_req_rdy_o), 64'(e_rdy));
            chk("rnd_rsp_vld", 64'(ch_resp_vld_o), 64'(e_rsp));
            chk("rnd_fg", 64'(flush_grant_o), 64'(flush_vld_i && !m_vld && all0));
            chk("rnd_nl_vld", 64'(nl_req_vld_o), 64'(m_vld));
            if (m_vld) begin
                chk("rnd_nl_id", 64'(nl_req_trans_id_o), 64'(m_id));
                chk("rnd_nl_asid", 64'(nl_req_asid_o), 64'(m_asid));
                chk("rnd_nl_vpn", 64'(nl_req_vpn_o), 64'(m_vpn));
                chk("rnd_nl_at", 64'(nl_req_access_type_o), 64'(m_at));
            end
            if (e_rsp != 2'b00) begin
                chk("rnd_rsp_id", 64'(ch_resp_trans_id_o), 64'(nl_resp_trans_id_i[1:0]));
                chk("rnd_rsp_pte", ch_resp_pte_o, nl_resp_pte_i);
                chk("rnd_rsp_asid", 64'(ch_resp_asid_o), 64'(nl_resp_asid_i));
            end

            if (m_vld && nl_req_rdy_i) delivered.push_back(m_id);
            if (g >= 0) begin
                m_vld  = 1'b1;
                m_id   = {1'(g), ch_req_trans_id_i[g*TID +: TID]};
                m_asid = ch_req_asid_i[g*AW +: AW];
                m_vpn  = ch_req_vpn_i[g*VW +: VW];
                m_at   = ch_req_access_type_i[g*2 +: 2];
                m_cnt[g]++;
                m_ptr  = (g + 1) % NUM_CH;
            end else if (nl_req_rdy_i) begin
                m_vld  = 1'b0;
            end
            if (e_rsp != 2'b00) m_cnt[rc]--;
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
